// File: rtl/qspi_psram_os.sv
// Oversampled QSPI PSRAM model: sck/cs/io are sampled as plain inputs in the clk_i domain.
// Handles SPI/QPI mode switching, 1- and 4-bit read/write, and the reset-enable/reset pair.
module qspi_psram_os #(
  parameter int    DEPTH        = 128,
  parameter int    ADR_BITS     = 24,
  parameter int    DUMMY_CYCLES = 6,
  parameter string INIT_FILE    = ""
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_in,
  input  logic [3:0] io_i,
  output logic [3:0] io_o,
  output logic [3:0] io_oe_o,
  output logic       qpi_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADR    = AW'(DEPTH - 1);
  localparam logic [7:0]    ADR_LAST_1  = 8'(ADR_BITS - 1);
  localparam logic [7:0]    ADR_LAST_4  = 8'(ADR_BITS / 4 - 1);
  localparam logic [7:0]    DUMMY_LAST  = 8'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {ST_CMD, ST_ADR, ST_DUMMY, ST_READ, ST_WRITE, ST_WAIT} state_t;

  logic [7:0]          mem_r [0:DEPTH-1];
  state_t              state_r, state_s;
  logic                sck_q_r;
  logic [7:0]          cnt_r, cnt_s;
  logic [ADR_BITS-1:0] shift_r, shift_s, shift_in_s;
  logic [7:0]          cmd_r, cmd_s;
  logic                wide_r, wide_s, cur_wide_s;
  logic                qpi_r, qpi_s;
  logic                rsten_r, rsten_s;
  logic [AW-1:0]       addr_r, addr_s, adr_mod_s, adr_inc_s;
  logic [7:0]          byte_r, byte_s;
  logic [3:0]          io_o_r, io_o_s;
  logic [3:0]          io_oe_r, io_oe_s;
  logic                we_s;
  logic                rise_s, fall_s;
  logic [7:0]          last_unit_s;

  assign rise_s      = ~sck_q_r & sck_i;
  assign fall_s      = sck_q_r & ~sck_i;
  assign cur_wide_s  = (state_r == ST_CMD) ? qpi_r : wide_r;
  assign shift_in_s  = cur_wide_s ? {shift_r[ADR_BITS-5:0], io_i} : {shift_r[ADR_BITS-2:0], io_i[0]};
  assign adr_mod_s   = AW'(shift_in_s % ADR_BITS'(DEPTH));
  assign adr_inc_s   = (addr_r == LAST_ADR) ? {AW{1'b0}} : addr_r + 1'b1;
  assign last_unit_s = wide_r ? 8'd1 : 8'd7;

  // Next-state and next-output logic for the protocol engine.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    cmd_s   = cmd_r;
    wide_s  = wide_r;
    qpi_s   = qpi_r;
    rsten_s = rsten_r;
    addr_s  = addr_r;
    byte_s  = byte_r;
    io_o_s  = io_o_r;
    we_s    = 1'b0;
    if (cs_in) begin
      state_s = ST_CMD;
      cnt_s   = 8'd0;
      shift_s = {ADR_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_CMD: begin
          if (rise_s) begin
            shift_s = shift_in_s;
            if (cnt_r == (qpi_r ? 8'd1 : 8'd7)) begin
              cnt_s   = 8'd0;
              cmd_s   = shift_in_s[7:0];
              rsten_s = 1'b0;
              state_s = ST_WAIT;
              case (shift_in_s[7:0])
                8'h35: qpi_s = 1'b1;
                8'hF5: qpi_s = 1'b0;
                8'h66: rsten_s = 1'b1;
                8'h99: qpi_s = rsten_r ? 1'b0 : qpi_r;
                8'h03, 8'h02: begin
                  wide_s  = qpi_r;
                  state_s = ST_ADR;
                end
                8'hEB, 8'h38: begin
                  wide_s  = 1'b1;
                  state_s = ST_ADR;
                end
                default: state_s = ST_WAIT;
              endcase
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_ADR: begin
          if (rise_s) begin
            shift_s = shift_in_s;
            if (cnt_r == (wide_r ? ADR_LAST_4 : ADR_LAST_1)) begin
              cnt_s  = 8'd0;
              addr_s = adr_mod_s;
              if ((cmd_r == 8'h02) || (cmd_r == 8'h38)) begin
                state_s = ST_WRITE;
                byte_s  = 8'h00;
              end else if ((cmd_r == 8'hEB) && (DUMMY_CYCLES != 0)) begin
                state_s = ST_DUMMY;
              end else begin
                state_s = ST_READ;
                byte_s  = mem_r[adr_mod_s];
              end
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_DUMMY: begin
          if (rise_s) begin
            if (cnt_r == DUMMY_LAST) begin
              cnt_s   = 8'd0;
              state_s = ST_READ;
              byte_s  = mem_r[addr_r];
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_READ: begin
          // Units go out on falls so the host can sample them on the following rise.
          if (fall_s) begin
            if (wide_r) begin
              io_o_s = cnt_r[0] ? byte_r[3:0] : byte_r[7:4];
            end else begin
              io_o_s = {2'b00, byte_r[3'd7 - cnt_r[2:0]], 1'b0};
            end
            if (cnt_r == last_unit_s) begin
              cnt_s  = 8'd0;
              addr_s = adr_inc_s;
              byte_s = mem_r[adr_inc_s];
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_WRITE: begin
          if (rise_s) begin
            byte_s = wide_r ? {byte_r[3:0], io_i} : {byte_r[6:0], io_i[0]};
            if (cnt_r == last_unit_s) begin
              we_s   = 1'b1;
              cnt_s  = 8'd0;
              addr_s = adr_inc_s;
            end else begin
              cnt_s = cnt_r + 8'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_WAIT: state_s = ST_WAIT;
        default: state_s = ST_CMD;
      endcase
    end
    io_oe_s = (state_s == ST_READ) ? (wide_s ? 4'b1111 : 4'b0010) : 4'b0000;
  end

  // Protocol state and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_CMD;
      sck_q_r <= 1'b0;
      cnt_r   <= 8'd0;
      shift_r <= {ADR_BITS{1'b0}};
      cmd_r   <= 8'h00;
      wide_r  <= 1'b0;
      qpi_r   <= 1'b0;
      rsten_r <= 1'b0;
      addr_r  <= {AW{1'b0}};
      byte_r  <= 8'h00;
      io_o_r  <= 4'b0000;
      io_oe_r <= 4'b0000;
    end else begin
      state_r <= state_s;
      sck_q_r <= sck_i;
      cnt_r   <= cnt_s;
      shift_r <= shift_s;
      cmd_r   <= cmd_s;
      wide_r  <= wide_s;
      qpi_r   <= qpi_s;
      rsten_r <= rsten_s;
      addr_r  <= addr_s;
      byte_r  <= byte_s;
      io_o_r  <= io_o_s;
      io_oe_r <= io_oe_s;
    end
  end

  // Byte commit; only complete bytes reach the array.
  always_ff @(posedge clk_i) begin
    if (we_s && !rst_i) mem_r[addr_r] <= byte_s;
  end

  assign io_o    = io_o_r;
  assign io_oe_o = cs_in ? 4'b0000 : io_oe_r;
  assign qpi_o   = qpi_r;

endmodule

// File: tb/tb_qspi_psram_os.sv
// Bench for qspi_psram_os: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a byte-array/mode-flag model.
module tb_qspi_psram_os;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out, io_oe;
  logic       qpi;

  qspi_psram_os dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_in(cs_n),
    .io_i(io_in), .io_o(io_out), .io_oe_o(io_oe), .qpi_o(qpi)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mem_m [128];
  logic       qpi_m = 1'b0;
  logic       rsten_m = 1'b0;

  logic [3:0] q_q [$];
  logic [3:0] oe_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] wdq [$];

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] adr;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        exp_qpi;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  // One sck period: present data, rise, fall, then sample what the fall drove.
  task automatic unit(input logic [3:0] d);
    io_in = d;
    sck = 1'b1;
    repeat (3) @(negedge clk);
    sck = 1'b0;
    repeat (3) @(negedge clk);
    q_q.push_back(io_out);
    oe_q.push_back(io_oe);
  endtask

  task automatic send_bits(input logic [23:0] v, input int nbits, input int w);
    for (int i = nbits / w - 1; i >= 0; i--) begin
      if (w == 4) unit(v[i*4 +: 4]);
      else unit({3'b000, v[i]});
    end
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_hi();
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Full transaction; read bytes land in rd_q, model is updated afterwards.
  task automatic txn(input logic [7:0] cmd, input logic [23:0] adr, input int n);
    int  cw, dw, upb, start, idx, bad;
    bit  rd, wr;
    logic [7:0] b;
    logic [3:0] oe_exp;
    rd = (cmd == 8'h03) || (cmd == 8'hEB);
    wr = (cmd == 8'h02) || (cmd == 8'h38);
    cw = qpi_m ? 4 : 1;
    dw = ((cmd == 8'hEB) || (cmd == 8'h38)) ? 4 : cw;
    upb = (dw == 4) ? 2 : 8;
    q_q.delete(); oe_q.delete(); rd_q.delete();
    cs_lo();
    send_bits({16'h0000, cmd}, 8, cw);
    if (rd || wr) send_bits(adr, 24, dw);
    if (cmd == 8'hEB) repeat (6) unit(4'h0);
    if (wr) foreach (wdq[j]) send_bits({16'h0000, wdq[j]}, 8, dw);
    if (rd) repeat (n * upb) unit(4'h0);
    cs_hi();
    start = (8 / cw) + (rd ? 24 / dw : 0) + ((cmd == 8'hEB) ? 6 : 0) - 1;
    if (rd) begin
      for (int j = 0; j < n; j++) begin
        b = 8'h00;
        for (int u = 0; u < upb; u++) begin
          idx = start + j * upb + u;
          if (dw == 4) b = {b[3:0], q_q[idx]};
          else b = {b[6:0], q_q[idx][1]};
        end
        rd_q.push_back(b);
      end
    end
    bad = 0;
    oe_exp = (dw == 4) ? 4'b1111 : 4'b0010;
    for (int k = 0; k < oe_q.size(); k++) begin
      if (rd && k >= start) begin
        if (oe_q[k] !== oe_exp) bad++;
      end else if (oe_q[k] !== 4'b0000) bad++;
    end
    chk($sformatf("oe_phase_cmd%02h", cmd), bad, 0);
    if (wr) foreach (wdq[j]) mem_m[(adr % 128 + j) % 128] = wdq[j];
    if (cmd == 8'h35) qpi_m = 1'b1;
    if (cmd == 8'hF5) qpi_m = 1'b0;
    if (cmd == 8'h99 && rsten_m) qpi_m = 1'b0;
    rsten_m = (cmd == 8'h66);
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [23:0] adr;
    int          n, r;

    tbl[0]  = '{8'h02, 24'h000010, 2, 8'hA5, 8'h3C, 1'b0};
    tbl[1]  = '{8'h03, 24'h000010, 2, 8'hA5, 8'h3C, 1'b0};
    tbl[2]  = '{8'h35, 24'h000000, 0, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{8'h38, 24'h00007F, 2, 8'h11, 8'h22, 1'b1};
    tbl[4]  = '{8'hEB, 24'h00007F, 2, 8'h11, 8'h22, 1'b1};
    tbl[5]  = '{8'h03, 24'h000000, 1, 8'h22, 8'h00, 1'b1};
    tbl[6]  = '{8'h66, 24'h000000, 0, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{8'h99, 24'h000000, 0, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h35, 24'h000000, 0, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{8'h66, 24'h000000, 0, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{8'h03, 24'h000010, 1, 8'hA5, 8'h00, 1'b1};
    tbl[11] = '{8'h99, 24'h000000, 0, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{8'hF5, 24'h000000, 0, 8'h00, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_io_o", io_out, 4'h0);
    chk("rst_io_oe", io_oe, 4'h0);
    chk("rst_qpi", qpi, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      wdq.delete();
      if (tbl[i].cmd == 8'h02 || tbl[i].cmd == 8'h38) begin
        wdq.push_back(tbl[i].d0);
        if (tbl[i].n == 2) wdq.push_back(tbl[i].d1);
      end
      txn(tbl[i].cmd, tbl[i].adr, tbl[i].n);
      if (tbl[i].cmd == 8'h03 || tbl[i].cmd == 8'hEB) begin
        chk($sformatf("vec%0d_byte0", i), rd_q[0], tbl[i].d0);
        if (tbl[i].n == 2) chk($sformatf("vec%0d_byte1", i), rd_q[1], tbl[i].d1);
      end
      chk($sformatf("vec%0d_qpi", i), qpi, tbl[i].exp_qpi);
    end

    // Deselect right after the first quad-read nibble drops the drivers at once.
    wdq.delete();
    txn(8'h35, 24'h0, 0);
    q_q.delete(); oe_q.delete();
    cs_lo();
    send_bits(24'h0000EB, 8, 4);
    send_bits(24'h00007F, 24, 4);
    repeat (6) unit(4'h0);
    chk("desel_first_nibble", q_q[q_q.size() - 1], 4'h1);
    chk("desel_oe_before", io_oe, 4'b1111);
    cs_n = 1'b1;
    #1;
    chk("desel_oe_same_clk", io_oe, 4'b0000);
    repeat (3) @(negedge clk);
    txn(8'h03, 24'h00007F, 1);
    chk("desel_next_read", rd_q[0], mem_m[127]);

    // A lone nibble followed by deselect must not reach memory.
    wdq.delete();
    wdq.push_back(8'h5A);
    txn(8'h38, 24'h000005, 1);
    cs_lo();
    send_bits(24'h000038, 8, 4);
    send_bits(24'h000005, 24, 4);
    unit(4'hF);
    cs_hi();
    txn(8'hEB, 24'h000005, 1);
    chk("partial_write_discard", rd_q[0], 8'h5A);

    // Fill memory so random reads see defined data.
    wdq.delete();
    for (int i = 0; i < 128; i++) wdq.push_back(8'($urandom));
    txn(8'h38, 24'h000000, 128);
    wdq.delete();

    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      wdq.delete();
      if (r == 0) begin
        cmd = qpi_m ? 8'hF5 : 8'h35;
        txn(cmd, 24'h0, 0);
      end else begin
        case ($urandom_range(0, 3))
          0: cmd = 8'h02;
          1: cmd = 8'h03;
          2: cmd = 8'h38;
          default: cmd = 8'hEB;
        endcase
        adr = 24'($urandom);
        n = $urandom_range(1, 3);
        if (cmd == 8'h02 || cmd == 8'h38) begin
          for (int j = 0; j < n; j++) wdq.push_back(8'($urandom));
        end
        txn(cmd, adr, n);
        if (cmd == 8'h03 || cmd == 8'hEB) begin
          for (int j = 0; j < n; j++)
            chk($sformatf("rand%0d_rd%0d", t, j), rd_q[j], mem_m[(adr % 128 + j) % 128]);
        end
      end
      chk($sformatf("rand%0d_qpi", t), qpi, qpi_m);
    end

    // Reset during a read burst: drivers and mode drop immediately, memory survives.
    if (!qpi_m) txn(8'h35, 24'h0, 0);
    q_q.delete(); oe_q.delete();
    cs_lo();
    send_bits(24'h000003, 8, 4);
    send_bits(24'h000010, 24, 4);
    unit(4'h0);
    unit(4'h0);
    chk("rst_mid_read_oe_before", io_oe, 4'b1111);
    rst = 1'b1;
    #1;
    chk("rst_mid_read_oe", io_oe, 4'b0000);
    chk("rst_mid_read_qpi", qpi, 1'b0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qpi_m = 1'b0;
    rsten_m = 1'b0;
    repeat (2) @(negedge clk);
    txn(8'h03, 24'h000010, 2);
    chk("post_rst_rd0", rd_q[0], mem_m[16]);
    chk("post_rst_rd1", rd_q[1], mem_m[17]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
